bios_port_arbiter: RTL and testbench

BIOS_PORT_ARBITER -- requirements
Module: bios_port_arbiter

---
 rtl/bios_port_arbiter_if.sv | 29 ++
 rtl/bios_port_arbiter.sv | 71 +++++++
 tb/tb_bios_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bios_port_arbiter_if.sv
// Request/response bundle between fetch/load requesters, the BIOS RAM and the arbiter.
// master: requesters plus RAM model; slave: the arbiter.
interface bios_port_arbiter_if;
    logic        freeze;
    logic        if_req;
    logic [31:0] if_pc;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        bios_en;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic        if_valid;
    logic [31:0] if_data;
    logic        dm_valid;
    logic [31:0] dm_data;
    logic        if_stall;
    logic        dm_stall;

    // Handshake: a request is offered every cycle it is held; a cycle-N grant is shown by
    // bios_en=1, the loser sees its stall in N, and the winner's valid pulses in N+1.
    modport master (
        output freeze, if_req, if_pc, dm_req, dm_addr, bios_dout,
        input  bios_en, bios_addr, if_valid, if_data, dm_valid, dm_data, if_stall, dm_stall
    );
    modport slave (
        input  freeze, if_req, if_pc, dm_req, dm_addr, bios_dout,
        output bios_en, bios_addr, if_valid, if_data, dm_valid, dm_data, if_stall, dm_stall
    );
endinterface

// File: rtl/bios_port_arbiter.sv
// Arbitrates instruction fetch and data load onto one synchronous BIOS RAM read port,
// loads preferred, with a starvation limit that forces a fetch grant.
module bios_port_arbiter #(
    parameter int STARVE_LIM = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bios_port_arbiter_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int CW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_IF   = 2'd1,
        ST_DM   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve;
    logic [31:0]   if_hold;
    logic [31:0]   dm_hold;

    logic elig_if, elig_dm, starve_hit, grant_if, grant_dm;
    logic unused_addr_bits;

    assign elig_if    = bus.if_req && (bus.if_pc[31:28] == 4'b0100);
    assign elig_dm    = bus.dm_req && (bus.dm_addr[31:28] == 4'b0100);
    assign starve_hit = (starve == CW'(STARVE_LIM));

    // reset_n gates the combinational path so reset wins regardless of requests.
    assign grant_if = reset_n && !bus.freeze && elig_if && (!elig_dm || starve_hit);
    assign grant_dm = reset_n && !bus.freeze && elig_dm && !grant_if;

    assign bus.bios_en   = grant_if || grant_dm;
    assign bus.bios_addr = grant_if ? bus.if_pc[13:2] :
                           grant_dm ? bus.dm_addr[13:2] : 12'd0;
    assign bus.if_stall  = reset_n && elig_if && !grant_if;
    assign bus.dm_stall  = reset_n && elig_dm && !grant_dm;

    assign bus.if_valid = (state == ST_IF);
    assign bus.dm_valid = (state == ST_DM);
    assign bus.if_data  = bus.if_valid ? bus.bios_dout : if_hold;
    assign bus.dm_data  = bus.dm_valid ? bus.bios_dout : dm_hold;
    assign dbg_state    = state;

    assign unused_addr_bits = ^{bus.if_pc[27:14], bus.if_pc[1:0],
                                bus.dm_addr[27:14], bus.dm_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_NONE;
            starve  <= '0;
            if_hold <= '0;
            dm_hold <= '0;
        end else begin
            if (grant_if)      state <= ST_IF;
            else if (grant_dm) state <= ST_DM;
            else               state <= ST_NONE;

            // Frozen cycles are not losses; the counter just waits.
            if (!bus.freeze) begin
                if (grant_if || !elig_if) starve <= '0;
                else if (!starve_hit)     starve <= starve + 1'b1;
            end

            if (state == ST_IF) if_hold <= bus.bios_dout;
            if (state == ST_DM) dm_hold <= bus.bios_dout;
        end
    end
endmodule

// File: tb/tb_bios_port_arbiter.sv
// Vector-table bench for bios_port_arbiter with a BIOS RAM model and a queue of expected
// N+1 deliveries checked against valid/data outputs.
module tb_bios_port_arbiter;
    localparam int W = 34;

    logic       clk;
    logic       reset_n;
    logic [1:0] dbg_state;

    bios_port_arbiter_if bus ();

    bios_port_arbiter #(.STARVE_LIM(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic        fr;
        logic        ir;
        logic [31:0] ipc;
        logic        dr;
        logic [31:0] dad;
        logic        en;
        logic [11:0] ad;
        logic        is;
        logic        ds;
        logic [1:0]  g;   // 0 none, 1 fetch, 2 load
    } vec_t;

    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_if_hold;
    logic [31:0]  exp_dm_hold;
    int           total;
    int           bad;
    vec_t         tbl[19];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {a, 8'h5A, ~a};
    endfunction

    always @(posedge clk) if (bus.bios_en) bus.bios_dout <= mem_word(bus.bios_addr);

    function automatic vec_t mk(input logic fr, input logic ir, input logic [31:0] ipc,
                                input logic dr, input logic [31:0] dad, input logic en,
                                input logic [11:0] ad, input logic is, input logic ds,
                                input logic [1:0] g);
        vec_t v;
        v.fr = fr; v.ir = ir; v.ipc = ipc; v.dr = dr; v.dad = dad;
        v.en = en; v.ad = ad; v.is = is; v.ds = ds; v.g = g;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.freeze  = v.fr;
        bus.if_req  = v.ir;
        bus.if_pc   = v.ipc;
        bus.dm_req  = v.dr;
        bus.dm_addr = v.dad;
    endtask

    task automatic check_delivery(input string tag);
        logic [W-1:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        if (e[33:32] == 2'd1) exp_if_hold = e[31:0];
        if (e[33:32] == 2'd2) exp_dm_hold = e[31:0];
        check({tag, " if_valid"}, 32'(bus.if_valid), 32'(e[33:32] == 2'd1));
        check({tag, " dm_valid"}, 32'(bus.dm_valid), 32'(e[33:32] == 2'd2));
        check({tag, " if_data"},  bus.if_data, exp_if_hold);
        check({tag, " dm_data"},  bus.dm_data, exp_dm_hold);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check({tag, " bios_en"},   32'(bus.bios_en),  32'(v.en));
        check({tag, " bios_addr"}, 32'(bus.bios_addr), 32'(v.ad));
        check({tag, " if_stall"},  32'(bus.if_stall), 32'(v.is));
        check({tag, " dm_stall"},  32'(bus.dm_stall), 32'(v.ds));
        check_delivery(tag);
        exp_q.push_back({v.g, (v.g != 2'd0) ? mem_word(v.ad) : 32'd0});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bios_en"},   32'(bus.bios_en),   32'd0);
        check({tag, " bios_addr"}, 32'(bus.bios_addr), 32'd0);
        check({tag, " if_stall"},  32'(bus.if_stall),  32'd0);
        check({tag, " dm_stall"},  32'(bus.dm_stall),  32'd0);
        check({tag, " if_valid"},  32'(bus.if_valid),  32'd0);
        check({tag, " dm_valid"},  32'(bus.dm_valid),  32'd0);
        check({tag, " if_data"},   bus.if_data,        32'd0);
        check({tag, " dm_data"},   bus.dm_data,        32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_if_hold = '0;
        exp_dm_hold = '0;

        //            fr ir ipc           dr dad           en ad      is ds g
        tbl[0]  = mk(0, 1, 32'h4000_0010, 0, 32'h0,        1, 12'h004, 0, 0, 1);
        tbl[1]  = mk(0, 1, 32'h1000_0000, 0, 32'h0,        0, 12'h000, 0, 0, 0);
        tbl[2]  = mk(0, 1, 32'h4000_0000, 1, 32'h4000_0FFC, 1, 12'h3FF, 1, 0, 2);
        tbl[3]  = mk(0, 1, 32'h4000_0000, 1, 32'h4000_0FFC, 1, 12'h3FF, 1, 0, 2);
        tbl[4]  = mk(0, 1, 32'h4000_0000, 1, 32'h4000_0FFC, 1, 12'h3FF, 1, 0, 2);
        tbl[5]  = mk(0, 1, 32'h4000_0000, 1, 32'h4000_0FFC, 1, 12'h000, 0, 1, 1);
        tbl[6]  = mk(0, 1, 32'h4000_0000, 1, 32'h4000_0FFC, 1, 12'h3FF, 1, 0, 2);
        tbl[7]  = mk(0, 1, 32'h4000_0104, 0, 32'h0,        1, 12'h041, 0, 0, 1);
        tbl[8]  = mk(0, 0, 32'h4000_0000, 1, 32'h4FFF_E008, 1, 12'h802, 0, 0, 2);
        tbl[9]  = mk(0, 1, 32'h4000_3FFF, 0, 32'h0,        1, 12'hFFF, 0, 0, 1);
        tbl[10] = mk(0, 0, 32'h0,         1, 32'h4000_0FFC, 1, 12'h3FF, 0, 0, 2);
        tbl[11] = mk(0, 1, 32'h4000_0020, 1, 32'h5000_0010, 1, 12'h008, 0, 0, 1);
        tbl[12] = mk(1, 1, 32'h4000_0030, 1, 32'h4000_0040, 0, 12'h000, 1, 1, 0);
        tbl[13] = mk(0, 0, 32'h4000_0030, 0, 32'h4000_0040, 0, 12'h000, 0, 0, 0);
        tbl[14] = mk(0, 1, 32'h4000_0030, 1, 32'h4000_0044, 1, 12'h011, 1, 0, 2);
        tbl[15] = mk(0, 1, 32'h4000_0030, 1, 32'h4000_0048, 1, 12'h012, 1, 0, 2);
        tbl[16] = mk(1, 1, 32'h4000_0030, 1, 32'h4000_004C, 0, 12'h000, 1, 1, 0);
        tbl[17] = mk(0, 1, 32'h4000_0030, 1, 32'h4000_0050, 1, 12'h014, 1, 0, 2);
        tbl[18] = mk(0, 1, 32'h4000_0034, 1, 32'h4000_0054, 1, 12'h00D, 0, 1, 1);

        // Reset holds every output low even with eligible requests on the inputs.
        reset_n = 1'b0;
        drive(mk(0, 1, 32'h4000_0000, 1, 32'h4000_0004, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_all_zero("reset");
        check("reset state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        run_vec(mk(0, 0, 32'h0, 0, 32'h0, 0, 12'h000, 0, 0, 0), "drain");

        // Reset lands in the delivery cycle of a fetch grant: that valid must never appear.
        run_vec(mk(0, 1, 32'h4000_0040, 0, 32'h0, 1, 12'h010, 0, 0, 1), "pre_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(mk(0, 1, 32'h4000_0000, 1, 32'h4000_0004, 0, 0, 0, 0, 0));
        exp_q.delete();
        exp_if_hold = '0;
        exp_dm_hold = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_all_zero($sformatf("mid_rst%0d", c));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_all_zero("post_rst");
        run_vec(mk(0, 0, 32'h0, 0, 32'h0, 0, 12'h000, 0, 0, 0), "idle_rst");
        run_vec(mk(0, 1, 32'h4000_0ABC, 0, 32'h0, 1, 12'h2AF, 0, 0, 1), "first_gnt");
        run_vec(mk(0, 0, 32'h0, 1, 32'h4000_0100, 1, 12'h040, 0, 0, 2), "dm_gnt");
        run_vec(mk(0, 0, 32'h0, 0, 32'h0, 0, 12'h000, 0, 0, 0), "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
